// File: rtl/tlcd_pkg.sv
// ============================================================================
// tlcd_pkg : shared commands, addresses and state encodings for the text LCD
// Revision : 1.0
// ============================================================================
`default_nettype none

package tlcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;

    localparam logic [7:0] ROW0_BASE    = 8'h80;
    localparam logic [7:0] ROW1_BASE    = 8'hC0;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    typedef enum logic [2:0] {
        ST_WAIT_EN  = 3'd0,
        ST_INIT0    = 3'd1,
        ST_INIT1    = 3'd2,
        ST_INIT2    = 3'd3,
        ST_INIT3    = 3'd4,
        ST_SCAN     = 3'd5,
        ST_SET_ADDR = 3'd6,
        ST_WRITE    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_HIGH  = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    // Cell idx of the {upper, lower} frame; cell 0 sits in the top byte.
    function automatic logic [7:0] frame_char(input logic [255:0] frame,
                                              input logic [4:0]   idx);
        return frame[{~idx, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlcd_bus_cycle.sv
// ============================================================================
// tlcd_bus_cycle : one HD44780 write cycle (setup, E high, execute wait)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlcd_bus_cycle
    import tlcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_HIGH_CYC     = 25,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(SETUP_CYC + E_HIGH_CYC + CMD_WAIT_CYC + CLEAR_WAIT_CYC + 1);

    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic             long_q;

    // Pulses during the last wait cycle so the caller can chain the next cycle
    // without an idle gap.
    assign done = (phase == PH_WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            busy     <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase    <= PH_SETUP;
                        cnt      <= CNT_W'(SETUP_CYC - 1);
                        long_q   <= long_wait;
                        lcd_rs   <= rs;
                        lcd_data <= data;
                        busy     <= 1'b1;
                    end
                end
                PH_SETUP: begin
                    if (cnt == '0) begin
                        phase <= PH_HIGH;
                        cnt   <= CNT_W'(E_HIGH_CYC - 1);
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PH_HIGH: begin
                    if (cnt == '0) begin
                        phase <= PH_WAIT;
                        lcd_e <= 1'b0;
                        cnt   <= long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt == '0) begin
                        phase <= PH_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlcd_diff_writer.sv
// ============================================================================
// tlcd_diff_writer : init the text LCD, then write only cells that changed
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlcd_diff_writer
    import tlcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_HIGH_CYC     = 25,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         ENABLE,
    input  logic [127:0] TEXT_STRING_UPPER,
    input  logic [127:0] TEXT_STRING_LOWER,
    output logic         TLCD_E,
    output logic         TLCD_RS,
    output logic         TLCD_RW,
    output logic [7:0]   TLCD_DATA,
    output logic         INIT_DONE,
    output logic         BUSY
);

    state_t     state;
    logic [4:0] ptr;
    logic [4:0] cursor;
    logic       cursor_valid;
    logic [7:0] ch;
    logic       in_cycle;
    logic       start;
    logic [7:0] shadow [32];

    logic         bus_done;
    logic         req_rs;
    logic [7:0]   req_data;
    logic         req_long;
    logic         bus_state;
    logic [7:0]   cur_char;
    logic [255:0] frame;

    assign TLCD_RW  = 1'b0;
    assign frame    = {TEXT_STRING_UPPER, TEXT_STRING_LOWER};
    assign cur_char = frame_char(frame, ptr);

    always_comb begin
        req_rs    = 1'b0;
        req_data  = 8'h00;
        req_long  = 1'b0;
        bus_state = 1'b1;
        case (state)
            ST_INIT0:    req_data = CMD_FUNC_SET;
            ST_INIT1:    req_data = CMD_DISP_ON;
            ST_INIT2:    req_data = CMD_ENTRY;
            ST_INIT3: begin
                req_data = CMD_CLEAR;
                req_long = 1'b1;
            end
            ST_SET_ADDR: req_data = (ptr[4] ? ROW1_BASE : ROW0_BASE) | {4'h0, ptr[3:0]};
            ST_WRITE: begin
                req_rs   = 1'b1;
                req_data = ch;
            end
            default:     bus_state = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state        <= ST_WAIT_EN;
            ptr          <= 5'd0;
            cursor       <= 5'd0;
            cursor_valid <= 1'b0;
            ch           <= 8'h00;
            in_cycle     <= 1'b0;
            start        <= 1'b0;
            INIT_DONE    <= 1'b0;
        end else begin
            start <= 1'b0;
            if (bus_state) begin
                // A started cycle always runs to completion; ENABLE only gates new ones.
                if (!in_cycle) begin
                    if (ENABLE) begin
                        start    <= 1'b1;
                        in_cycle <= 1'b1;
                    end
                end else if (bus_done) begin
                    in_cycle <= 1'b0;
                    case (state)
                        ST_INIT0: state <= ST_INIT1;
                        ST_INIT1: state <= ST_INIT2;
                        ST_INIT2: state <= ST_INIT3;
                        ST_INIT3: begin
                            state        <= ST_SCAN;
                            cursor       <= 5'd0;
                            cursor_valid <= 1'b1;
                            INIT_DONE    <= 1'b1;
                        end
                        ST_SET_ADDR: begin
                            state        <= ST_WRITE;
                            cursor       <= ptr;
                            cursor_valid <= 1'b1;
                        end
                        default: begin
                            // Column 15 does not auto-advance onto the other row.
                            state        <= ST_SCAN;
                            cursor       <= ptr + 5'd1;
                            cursor_valid <= (ptr[3:0] != 4'hF);
                            ptr          <= ptr + 5'd1;
                        end
                    endcase
                end
            end else if (state == ST_WAIT_EN) begin
                if (ENABLE) begin
                    state <= ST_INIT0;
                end
            end else if (ENABLE) begin
                if (cur_char == shadow[ptr]) begin
                    ptr <= ptr + 5'd1;
                end else begin
                    ch    <= cur_char;
                    state <= (cursor_valid && (cursor == ptr)) ? ST_WRITE : ST_SET_ADDR;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETN && in_cycle && bus_done) begin
            if (state == ST_INIT3) begin
                for (int i = 0; i < 32; i++) begin
                    shadow[i] <= CHAR_SPACE;
                end
            end else if (state == ST_WRITE) begin
                shadow[ptr] <= ch;
            end
        end
    end

    tlcd_bus_cycle #(
        .SETUP_CYC      (SETUP_CYC),
        .E_HIGH_CYC     (E_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_bus (
        .clk       (CLK),
        .resetn    (RESETN),
        .start     (start),
        .rs        (req_rs),
        .data      (req_data),
        .long_wait (req_long),
        .lcd_e     (TLCD_E),
        .lcd_rs    (TLCD_RS),
        .lcd_data  (TLCD_DATA),
        .busy      (BUSY),
        .done      (bus_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_tlcd_diff_writer.sv
// ============================================================================
// tb_tlcd_diff_writer : directed self-checking bench for tlcd_diff_writer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tlcd_diff_writer;

    logic         clk;
    logic         resetn;
    logic         enable;
    logic [127:0] upper;
    logic [127:0] lower;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    tlcd_diff_writer #(
        .SETUP_CYC      (1),
        .E_HIGH_CYC     (2),
        .CMD_WAIT_CYC   (3),
        .CLEAR_WAIT_CYC (10)
    ) dut (
        .CLK               (clk),
        .RESETN            (resetn),
        .ENABLE            (enable),
        .TEXT_STRING_UPPER (upper),
        .TEXT_STRING_LOWER (lower),
        .TLCD_E            (lcd_e),
        .TLCD_RS           (lcd_rs),
        .TLCD_RW           (lcd_rw),
        .TLCD_DATA         (lcd_data),
        .INIT_DONE         (init_done),
        .BUSY              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_char(input bit row, input int col, input logic [7:0] val);
        if (row) lower[8*(15-col) +: 8] = val;
        else     upper[8*(15-col) +: 8] = val;
    endtask

    // Waits (bounded) for E to rise; returns RS/DATA seen on that first high sample.
    task automatic wait_rise(output bit ok, output logic rs, output logic [7:0] d);
        int k;
        k = 0;
        while (lcd_e !== 1'b1 && k < 600) begin
            tick();
            k++;
        end
        ok = (lcd_e === 1'b1);
        rs = lcd_rs;
        d  = lcd_data;
    endtask

    // Counts E-high samples, returns at the first sample with E low again.
    task automatic count_high(output int hi);
        hi = 1;
        while (lcd_e === 1'b1 && hi < 100) begin
            tick();
            if (lcd_e === 1'b1) hi++;
        end
    endtask

    task automatic check_strobe(input string tag, input logic exp_rs, input logic [7:0] exp_d);
        bit         ok;
        logic       rs;
        logic [7:0] d;
        int         hi;
        wait_rise(ok, rs, d);
        chk({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            count_high(hi);
            chk({tag, "_rs"}, 32'(rs), 32'(exp_rs));
            chk({tag, "_data"}, 32'(d), 32'(exp_d));
            chk({tag, "_ehigh"}, 32'(hi), 32'd2);
        end
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int e_cnt;
        e_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (lcd_e !== 1'b0) e_cnt++;
        end
        chk({tag, "_no_e"}, 32'(e_cnt), 32'd0);
    endtask

    initial begin
        bit         ok;
        logic       rs;
        logic [7:0] d;
        int         hi;
        int         busy_cnt;

        resetn = 1'b0;
        enable = 1'b1;
        upper  = {16{8'h20}};
        lower  = {16{8'h20}};

        // Reset state
        tick();
        tick();
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;

        // Init sequence and INIT_DONE timing after the clear strobe falls
        check_strobe("init_38", 1'b0, 8'h38);
        check_strobe("init_0c", 1'b0, 8'h0C);
        check_strobe("init_06", 1'b0, 8'h06);
        check_strobe("init_01", 1'b0, 8'h01);
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_done_t0", 32'(init_done), 32'd0);
        repeat (9) tick();
        chk("clr_done_t9", 32'(init_done), 32'd0);
        tick();
        chk("clr_done_t10", 32'(init_done), 32'd1);

        // All spaces: nothing to write
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (lcd_e !== 1'b0) busy_cnt += 1000;
            if (busy !== 1'b0) busy_cnt++;
        end
        chk("blank_activity", 32'(busy_cnt), 32'd0);

        // Single cell needs an address, then the neighbour rides the cursor
        set_char(1'b0, 3, "A");
        check_strobe("c3_addr", 1'b0, 8'h83);
        check_strobe("c3_data", 1'b1, 8'h41);
        set_char(1'b0, 4, "B");
        check_strobe("c4_data", 1'b1, 8'h42);

        // Column 15 write invalidates the cursor, so row 1 col 0 needs an address
        set_char(1'b0, 15, "Z");
        set_char(1'b1, 0, "Y");
        check_strobe("c15_addr", 1'b0, 8'h8F);
        check_strobe("c15_data", 1'b1, 8'h5A);
        check_strobe("r1c0_addr", 1'b0, 8'hC0);
        check_strobe("r1c0_data", 1'b1, 8'h59);

        // Input changes while its write is on the bus
        set_char(1'b0, 6, "C");
        check_strobe("c6_addr", 1'b0, 8'h86);
        wait_rise(ok, rs, d);
        chk("race_seen", 32'(ok), 32'd1);
        set_char(1'b0, 6, "D");
        count_high(hi);
        chk("race_rs", 32'(rs), 32'd1);
        chk("race_data", 32'(d), 32'h43);
        chk("race_ehigh", 32'(hi), 32'd2);
        chk("race_hold", 32'(lcd_data), 32'h43);
        check_strobe("redo_addr", 1'b0, 8'h86);
        check_strobe("redo_data", 1'b1, 8'h44);
        quiet_window("settled", 200);
        chk("settled_busy", 32'(busy), 32'd0);

        // Reset in the middle of an E-high phase
        set_char(1'b0, 0, "R");
        wait_rise(ok, rs, d);
        chk("mid_seen", 32'(ok), 32'd1);
        chk("mid_data", 32'(d), 32'h80);
        resetn = 1'b0;
        enable = 1'b0;
        tick();
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        quiet_window("disabled", 20);
        enable = 1'b1;
        check_strobe("reinit_38", 1'b0, 8'h38);

        // ENABLE drops between init steps: hold, then continue with the next step
        enable = 1'b0;
        quiet_window("paused", 30);
        chk("paused_init_done", 32'(init_done), 32'd0);
        enable = 1'b1;
        check_strobe("resume_0c", 1'b0, 8'h0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
